// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-back bypass, two-word instruction assembly,
// load-use bubble insertion and the ID/EX register. Optional macro: DECODE_ZERO_REG_EN.
module decode_issue_stage #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned N_REGS  = 8,
    parameter int unsigned IW      = 16,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CTRL_W  = 32,
    parameter int unsigned RS1_LSB = 8,
    parameter int unsigned RS2_LSB = 5,
    localparam int unsigned AW     = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     instruction_i,
    input  logic              instr_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              ctrl_two_word_i,
    input  logic              ctrl_uses_rs1_i,
    input  logic              ctrl_uses_rs2_i,
    input  logic              ctrl_mem_read_i,
    input  logic              flush_decode_i,
    input  logic              stall_ex_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [WIDTH-1:0]  wb_data_i,
    output logic              stall_fetch_o,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_mem_read_o,
    output logic [WIDTH-1:0]  ex_rd1_o,
    output logic [WIDTH-1:0]  ex_rd2_o,
    output logic [WIDTH-1:0]  ex_imm_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [AW-1:0]     ex_rd_addr_o,
    output logic [AW-1:0]     ex_rs1_addr_o,
    output logic [AW-1:0]     ex_rs2_addr_o
);

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZeroRegEn = 1'b1;
`else
    localparam bit ZeroRegEn = 1'b0;
`endif

    typedef enum logic {StOp, StImm} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [N_REGS];
    logic [CTRL_W-1:0] hold_ctrl_q, hold_ctrl_d;
    logic              hold_mr_q, hold_mr_d;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
    logic [AW-1:0]     hold_rs1_q, hold_rs1_d, hold_rs2_q, hold_rs2_d;

    logic              ex_valid_q, ex_valid_d, ex_mr_q, ex_mr_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [WIDTH-1:0]  ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d, ex_imm_q, ex_imm_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;

    logic [AW-1:0]     rs1, rs2, ra1, ra2;
    logic [WIDTH-1:0]  rd1, rd2, imm_ext;
    logic [WIDTH+IW-1:0] imm_wide;
    logic              hz, hit1, hit2, load_ex;

    assign rs1 = instruction_i[RS1_LSB +: AW];
    assign rs2 = instruction_i[RS2_LSB +: AW];
    // In StImm the operands come from the addresses captured with the opcode word.
    assign ra1 = (state_q == StImm) ? hold_rs1_q : rs1;
    assign ra2 = (state_q == StImm) ? hold_rs2_q : rs2;
    assign imm_wide = {{WIDTH{1'b0}}, instruction_i};
    assign imm_ext  = imm_wide[WIDTH-1:0];

    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (wb_we_i && wb_addr_i == ra1) rd1 = wb_data_i;
        if (wb_we_i && wb_addr_i == ra2) rd2 = wb_data_i;
        if (ZeroRegEn && ra1 == '0) rd1 = '0;
        if (ZeroRegEn && ra2 == '0) rd2 = '0;
    end

    assign hit1 = ctrl_uses_rs1_i && rs1 == ex_rd_q && !(ZeroRegEn && rs1 == '0);
    assign hit2 = ctrl_uses_rs2_i && rs2 == ex_rd_q && !(ZeroRegEn && rs2 == '0);
    assign hz   = (state_q == StOp) && instr_valid_i && ex_valid_q && ex_mr_q && (hit1 || hit2);

    assign stall_fetch_o = !reset && !flush_decode_i && (stall_ex_i || hz);
    assign load_ex       = flush_decode_i || !stall_ex_i;

    always_comb begin
        state_d     = state_q;
        hold_ctrl_d = hold_ctrl_q;
        hold_mr_d   = hold_mr_q;
        hold_pc_d   = hold_pc_q;
        hold_rs1_d  = hold_rs1_q;
        hold_rs2_d  = hold_rs2_q;
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_mr_d     = ex_mr_q;
        ex_rd1_d    = ex_rd1_q;
        ex_rd2_d    = ex_rd2_q;
        ex_imm_d    = ex_imm_q;
        ex_pc_d     = ex_pc_q;
        ex_rd_d     = ex_rd_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;

        // Every edge that loads EX starts from a cleared bubble; issue overrides it.
        if (load_ex) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_mr_d    = 1'b0;
            ex_rd1_d   = '0;
            ex_rd2_d   = '0;
            ex_imm_d   = '0;
            ex_pc_d    = '0;
            ex_rd_d    = '0;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
        end

        if (flush_decode_i) begin
            state_d     = StOp;
            hold_ctrl_d = '0;
            hold_mr_d   = 1'b0;
            hold_pc_d   = '0;
            hold_rs1_d  = '0;
            hold_rs2_d  = '0;
        end else if (!stall_ex_i && !hz && instr_valid_i) begin
            unique case (state_q)
                StOp: begin
                    if (ctrl_two_word_i) begin
                        hold_ctrl_d = ctrl_i;
                        hold_mr_d   = ctrl_mem_read_i;
                        hold_pc_d   = pc_i;
                        hold_rs1_d  = rs1;
                        hold_rs2_d  = rs2;
                        state_d     = StImm;
                    end else begin
                        ex_valid_d = 1'b1;
                        ex_ctrl_d  = ctrl_i;
                        ex_mr_d    = ctrl_mem_read_i;
                        ex_pc_d    = pc_i;
                        ex_rd1_d   = rd1;
                        ex_rd2_d   = rd2;
                        ex_rd_d    = rs1;
                        ex_rs1_d   = rs1;
                        ex_rs2_d   = rs2;
                    end
                end
                StImm: begin
                    ex_valid_d = 1'b1;
                    ex_ctrl_d  = hold_ctrl_q;
                    ex_mr_d    = hold_mr_q;
                    ex_pc_d    = hold_pc_q;
                    ex_rd1_d   = rd1;
                    ex_rd2_d   = rd2;
                    ex_imm_d   = imm_ext;
                    ex_rd_d    = hold_rs1_q;
                    ex_rs1_d   = hold_rs1_q;
                    ex_rs2_d   = hold_rs2_q;
                    state_d    = StOp;
                end
                default: state_d = StOp;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_REGS); i++) regs_q[i] <= '0;
        end else if (wb_we_i && !(ZeroRegEn && wb_addr_i == '0)) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StOp;
            hold_ctrl_q <= '0;
            hold_mr_q   <= 1'b0;
            hold_pc_q   <= '0;
            hold_rs1_q  <= '0;
            hold_rs2_q  <= '0;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_mr_q     <= 1'b0;
            ex_rd1_q    <= '0;
            ex_rd2_q    <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_ctrl_q <= hold_ctrl_d;
            hold_mr_q   <= hold_mr_d;
            hold_pc_q   <= hold_pc_d;
            hold_rs1_q  <= hold_rs1_d;
            hold_rs2_q  <= hold_rs2_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_mr_q     <= ex_mr_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rd2_q    <= ex_rd2_d;
            ex_imm_q    <= ex_imm_d;
            ex_pc_q     <= ex_pc_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign ex_mem_read_o = ex_mr_q;
    assign ex_rd1_o      = ex_rd1_q;
    assign ex_rd2_o      = ex_rd2_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_rd_addr_o  = ex_rd_q;
    assign ex_rs1_addr_o = ex_rs1_q;
    assign ex_rs2_addr_o = ex_rs2_q;

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
Parametrised decode/issue stage for the pipelined core. Reads the register file with write-back bypass and assembles two-word (opcode + immediate) instructions with a small FSM. Detects load-use hazards and inserts bubbles. Drives the ID/EX pipeline register with stall, hold and flush. Sits between fetch and execute; control decode stays external and arrives as a flat bundle.

Parameters:
WIDTH, 16, register/data width
N_REGS, 8, register count (power of two); AW = $clog2(N_REGS) derived
IW, 16, instruction word width
PC_W, 32, PC width
CTRL_W, 32, width of opaque control bundle
RS1_LSB, 8, LSB of rs1 field (also rd field)
RS2_LSB, 5, LSB of rs2 field

Ports:
clk  in  1  clock
reset  in  1  reset
instruction  in  IW  fetched word
instr_valid  in  1  instruction holds a valid word
pc  in  PC_W  PC of instruction
ctrl_in  in  CTRL_W  control bundle from control unit
ctrl_two_word  in  1  opcode needs an immediate word
ctrl_uses_rs1 / ctrl_uses_rs2  in  1 each  source operand is read
ctrl_mem_read  in  1  instruction is a load
flush_decode  in  1  kill decode contents
stall_ex  in  1  back-pressure from execute
wb_we  in  1  write-back enable
wb_addr  in  AW  write-back address
wb_data  in  WIDTH  write-back data
stall_fetch  out  1  fetch must hold current word
ex_valid  out  1  EX register holds a real instruction
ex_ctrl  out  CTRL_W  registered control
ex_mem_read  out  1  registered ctrl_mem_read
ex_rd1 / ex_rd2  out  WIDTH each  operand values
ex_imm  out  WIDTH  immediate; zero-extended from IW/truncated to WIDTH; 0 for one-word instructions
ex_pc  out  PC_W  PC of first word
ex_rd_addr / ex_rs1_addr / ex_rs2_addr  out  AW each  register addresses

Behaviour:
- One clock. Reset is asynchronous and active-high. Named clk/reset.
- Reset: all EX outputs 0, register file 0, FSM S_OP. stall_fetch is combinational and 0 while reset is asserted.
- Register file: N_REGS x WIDTH, 2 combinational reads, 1 synchronous write on wb_we.
  - Bypass: if wb_we and wb_addr equals a read address, that read returns wb_data in the same cycle.
- Hazard: hz = S_OP & instr_valid & ex_valid & ex_mem_read & ((ctrl_uses_rs1 & rs1 == ex_rd_addr) | (ctrl_uses_rs2 & rs2 == ex_rd_addr)).
- stall_fetch = ~flush_decode & (stall_ex | hz).
- Priority per edge: flush_decode > stall_ex > hz > normal.
- flush: ex_valid=0, ex_ctrl=0, ex_mem_read=0, FSM to S_OP, held first-word fields dropped. Other EX fields don't-care (cleared). Register file writes continue.
- stall_ex: every EX register and FSM state hold.
- hz: bubble loaded (ex_valid=0, ctrl 0). FSM holds. The word is re-presented next cycle.
- FSM S_OP, instr_valid, ~ctrl_two_word: issue (ex_valid=1, fields from current word, imm=0). Latency 1 cycle.
- FSM S_OP, instr_valid, ctrl_two_word: latch ctrl_in, ctrl_mem_read, pc and register addresses into hold registers; emit bubble; go S_IMM.
- FSM S_OP, ~instr_valid: bubble.
- FSM S_IMM, instr_valid: issue using held fields; ex_imm = instruction; operands read at this edge using held addresses (with bypass); return S_OP. ctrl_* inputs ignored in S_IMM.
- FSM S_IMM, ~instr_valid: bubble, stay.
- Reset mid-S_IMM: to S_OP, hold registers cleared.

Optional Feature:
DECODE_ZERO_REG_EN defined: register 0 reads as 0 always, writes to it are discarded, bypass never applies to address 0, and hazard compare ignores rs == 0. Undefined: register 0 is an ordinary register.

Test Plan:
1. wb_we=1, wb_addr=3, wb_data=16'hBEEF with a one-word instruction rs1=3 in the same cycle -> next cycle ex_rd1=16'hBEEF, ex_valid=1, ex_imm=0.
2. Load with rd=2 issued, then an instruction with ctrl_uses_rs2=1 and rs2=2 -> stall_fetch=1 for 1 cycle; one bubble (ex_valid=0); instruction issues the following cycle.
3. Two-word opcode at pc=32'h10, then imm word 16'h1234 -> bubble, then ex_valid=1, ex_imm=16'h1234, ex_pc=32'h10.
4. Two-word opcode, then flush_decode with the immediate word -> ex_valid=0, FSM S_OP. Next word decoded as an opcode.
5. stall_ex=1 for 3 cycles with ex_valid=1, ex_rd1=16'h00AA -> EX outputs unchanged, stall_fetch=1; flush during stall_ex -> ex_valid=0, stall_fetch=0.
6. DECODE_ZERO_REG_EN: write 16'hFFFF to reg 0, read rs1=0 -> ex_rd1=0. Without the macro -> 16'hFFFF.
